// File: rtl/arb_pkg.sv
// arb_pkg: shared types, widths and one-hot/binary helpers for the 8-channel arbiter
//   N_REQ       number of requesters (fixed at 8)
//   ID_W        width of a requester index
//   arb_state_t arbiter FSM states
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W = 3;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
    function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
        return 8'b1 << id;
    endfunction
    function automatic logic [ID_W-1:0] onehot2id(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ; i++)
            if (oh[i]) id = ID_W'(i);
        return id;
    endfunction
endpackage

// File: rtl/rr_pick_8.sv
// rr_pick_8: combinational rotating priority encoder over 8 requests
//   req      in   8  request vector
//   start_id in   3  index searched first in rotating mode (search runs downward, wrapping 0->7)
//   rr_mode  in   1  1 = rotating start at start_id, 0 = fixed start at 7
//   found    out  1  at least one request set
//   id       out  3  index of the winning request, 0 when none
import arb_pkg::*;
module rr_pick_8 (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start_id,
    input  logic             rr_mode,
    output logic             found,
    output logic [ID_W-1:0]  id
);
    logic [ID_W-1:0] base;
    assign base = rr_mode ? start_id : ID_W'(N_REQ - 1);
    // Walk from farthest to nearest so the nearest hit to base is written last and wins.
    always_comb begin
        found = 1'b0;
        id = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[base - ID_W'(i)]) begin
                found = 1'b1;
                id = base - ID_W'(i);
            end
    end
endmodule

// File: rtl/rr_priority_arbiter_8ch.sv
// rr_priority_arbiter_8ch: registered 8-way arbiter with round-robin/fixed priority and hold watchdog
//   clk_i         in   1  clock
//   rst_n_i       in   1  asynchronous active-low reset
//   enable_i      in   1  arbitration allowed; low forces release
//   rr_mode_i     in   1  1 = round-robin, 0 = fixed priority (7 highest)
//   req_i         in   8  level-sensitive requests
//   done_i        in   1  owner releases the grant
//   grant_o       out  8  one-hot registered grant
//   grant_id_o    out  3  index of grant_o, 0 when no grant
//   grant_valid_o out  1  grant_o non-zero
//   timeout_o     out  1  one-cycle pulse on watchdog release
import arb_pkg::*;
module rr_priority_arbiter_8ch #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             rr_mode_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             grant_valid_o,
    output logic             timeout_o
);
    arb_state_t      state;
    logic [CNT_W-1:0] hold_cnt;
    logic [ID_W-1:0]  last_id;
    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic             wd_hit;
    logic             exit_now;
    logic             timeout_hit;

    // Previous owner is searched last: start one below it.
    rr_pick_8 u_pick (
        .req      (req_i),
        .start_id (last_id - ID_W'(1)),
        .rr_mode  (rr_mode_i),
        .found    (pick_found),
        .id       (pick_id)
    );

    assign wd_hit = hold_cnt == CNT_W'(MAX_HOLD - 1);
    assign exit_now = !enable_i || done_i || !req_i[grant_id_o] || wd_hit;
    // Watchdog only reports when no other release cause is present.
    assign timeout_hit = enable_i && !done_i && req_i[grant_id_o] && wd_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            hold_cnt <= '0;
            last_id <= '0;
            grant_o <= '0;
            grant_id_o <= '0;
            grant_valid_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: if (enable_i && pick_found) begin
                    state <= GRANT;
                    grant_o <= id2onehot(pick_id);
                    grant_id_o <= pick_id;
                    grant_valid_o <= 1'b1;
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (exit_now) begin
                        state <= RELEASE;
                        grant_o <= '0;
                        grant_id_o <= '0;
                        grant_valid_o <= 1'b0;
                        last_id <= grant_id_o;
                        timeout_o <= timeout_hit;
                    end
                end
                RELEASE: begin
                    hold_cnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_priority_arbiter_8ch.sv
// tb_rr_priority_arbiter_8ch: vector table, directed corner sequences and randomized model comparison
module tb_rr_priority_arbiter_8ch;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rr = 1'b0;
    logic       done = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: who owns the resource, for how many cycles, and the turnaround state.
    int   m_owner = -1;
    int   m_held = 0;
    int   m_dead = 0;
    int   m_last = 0;
    logic m_to = 1'b0;

    typedef struct {
        logic       en;
        logic       rr;
        logic       done;
        logic [7:0] req;
        logic       valid;
        logic [2:0] id;
        logic       to;
    } vec_t;
    vec_t tv[$];

    rr_priority_arbiter_8ch #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enable_i      (en),
        .rr_mode_i     (rr),
        .req_i         (req),
        .done_i        (done),
        .grant_o       (grant),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid),
        .timeout_o     (timeout)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void chk_out(input string tag, input logic v, input logic [2:0] id, input logic to);
        logic [7:0] eg;
        eg = v ? (8'd1 << id) : 8'd0;
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_id"}, 32'(grant_id), 32'(v ? id : 3'd0));
        chk({tag, "_valid"}, 32'(grant_valid), 32'(v));
        chk({tag, "_timeout"}, 32'(timeout), 32'(to));
    endfunction

    function automatic void add(input logic e, input logic r, input logic d, input logic [7:0] q,
                                input logic v, input logic [2:0] i, input logic t);
        vec_t x;
        x.en = e; x.rr = r; x.done = d; x.req = q; x.valid = v; x.id = i; x.to = t;
        tv.push_back(x);
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_held = 0; m_dead = 0; m_last = 0; m_to = 1'b0;
    endfunction

    function automatic void model_edge();
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!en || done || !req[m_owner] || m_held == MAX_HOLD) begin
                m_to = en && !done && req[m_owner] && (m_held == MAX_HOLD);
                m_last = m_owner;
                m_owner = -1;
                m_dead = 1;
            end else m_held++;
        end else if (m_dead != 0) begin
            m_dead = 0;
        end else if (en && req != 8'h00) begin
            if (!rr) begin
                for (int k = 0; k < 8; k++)
                    if (req[k]) m_owner = k;
            end else begin
                // Distance 1 below the last owner is best; distance 8 (the owner itself) is worst.
                for (int k = 8; k >= 1; k--) begin
                    int c;
                    c = (m_last - k + 16) % 8;
                    if (req[c]) m_owner = c;
                end
            end
            m_held = 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        en = 1'b0; rr = 1'b0; done = 1'b0; req = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_out("reset", 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Fixed priority, requester drop, enable low in IDLE, done ignored in IDLE.
        add(1, 0, 0, 8'hA0, 1, 7, 0);
        add(1, 0, 1, 8'hA0, 0, 0, 0);
        add(1, 0, 0, 8'h20, 0, 0, 0);
        add(1, 0, 0, 8'h20, 1, 5, 0);
        add(1, 0, 1, 8'h20, 0, 0, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 8'h10, 1, 4, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 8'hFF, 0, 0, 0);
        add(0, 1, 0, 8'hFF, 0, 0, 0);
        add(1, 1, 0, 8'hFF, 1, 3, 0);
        add(1, 1, 1, 8'hFF, 0, 0, 0);
        add(1, 0, 0, 8'hFF, 0, 0, 0);
        add(1, 0, 0, 8'hFF, 1, 7, 0);
        add(1, 0, 1, 8'hFF, 0, 0, 0);
        add(1, 1, 1, 8'h01, 0, 0, 0);
        add(1, 1, 1, 8'h01, 1, 0, 0);

        reset_dut();
        foreach (tv[i]) begin
            en = tv[i].en; rr = tv[i].rr; done = tv[i].done; req = tv[i].req;
            step();
            chk_out($sformatf("vec%0d", i), tv[i].valid, tv[i].id, tv[i].to);
        end

        // Round robin over a full request bank, done right after each grant.
        reset_dut();
        en = 1'b1; rr = 1'b1; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            done = 1'b0;
            step();
            chk_out($sformatf("rr%0d", k), 1'b1, 3'((7 - k) & 7), 1'b0);
            done = 1'b1;
            step();
            chk_out($sformatf("rr%0d_gap1", k), 1'b0, 3'd0, 1'b0);
            done = 1'b0;
            step();
            chk_out($sformatf("rr%0d_gap2", k), 1'b0, 3'd0, 1'b0);
        end

        // Watchdog: grant visible for MAX_HOLD cycles, one timeout pulse, then re-grant.
        reset_dut();
        en = 1'b1; rr = 1'b1; req = 8'h04;
        for (int k = 0; k < MAX_HOLD; k++) begin
            step();
            chk_out($sformatf("wd_hold%0d", k), 1'b1, 3'd2, 1'b0);
        end
        step();
        chk_out("wd_fire", 1'b0, 3'd0, 1'b1);
        step();
        chk_out("wd_dead", 1'b0, 3'd0, 1'b0);
        step();
        chk_out("wd_regrant", 1'b1, 3'd2, 1'b0);

        // done on the watchdog cycle wins, no pulse.
        for (int k = 1; k < MAX_HOLD; k++) step();
        chk_out("col_last", 1'b1, 3'd2, 1'b0);
        done = 1'b1;
        step();
        chk_out("col_done", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        step();
        step();
        chk_out("col_regrant", 1'b1, 3'd2, 1'b0);

        // enable low mid-grant drops the grant and blocks new ones.
        step();
        en = 1'b0;
        step();
        chk_out("en_drop", 1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("en_low%0d", k), 1'b0, 3'd0, 1'b0);
        end

        // Async reset mid-grant with no clock edge.
        en = 1'b1;
        step();
        step();
        chk_out("pre_rst", 1'b1, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_out("async_rst", 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Randomized traffic against the model.
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) req = 8'($urandom);
            if ($urandom_range(0, 39) == 0) rr = ~rr;
            done = ($urandom_range(0, 29) == 0);
            en = ($urandom_range(0, 49) != 0);
            step();
            chk_out("rnd", m_owner >= 0, 3'(m_owner >= 0 ? m_owner : 0), m_to);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
